// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter sharing one account ledger among NUM_REQ ATM controllers.
// Optional feature: define ATM_DAILY_LIMIT_EN to enforce a per-day cumulative withdrawal cap.
module atm_ledger_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int AMT_W        = 16,
  parameter int INIT_BALANCE = 1000,
  parameter int DAILY_LIMIT  = 500
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [AMT_W*NUM_REQ-1:0]     req_amount,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [1:0]                   rsp_status,
  output logic [AMT_W-1:0]             rsp_balance,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  input  logic                         day_rollover
);

  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] OP_INQUIRY  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;
  localparam logic [1:0] OP_DEPOSIT  = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NOFUNDS  = 2'b01;
  localparam logic [1:0] ST_LIMIT    = 2'b10;
  localparam logic [1:0] ST_REJECT   = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   balance_q, balance_d;
  logic [IDW-1:0]     rrPtr_q, rrPtr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [1:0]         op_q, op_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [1:0]         status_q, status_d;
  logic [AMT_W-1:0]   rspBal_q, rspBal_d;

  logic               winFound;
  logic [IDW-1:0]     winIdx;
  logic [IDW:0]       cand;
  logic [IDW:0]       nextPtr;
  logic [AMT_W:0]     depositSum;

`ifdef ATM_DAILY_LIMIT_EN
  logic [AMT_W-1:0]   acc_q, acc_d;
  logic [AMT_W-1:0]   accEff;
  logic [AMT_W:0]     accSum;
`else
  logic               unusedDayRollover;
  assign unusedDayRollover = day_rollover;
`endif

  // Scan from the round-robin pointer upward, wrapping, for the first valid requester.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rrPtr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!winFound && req_valid[cand[IDW-1:0]]) begin
        winFound = 1'b1;
        winIdx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    nextPtr = {1'b0, id_q} + (IDW+1)'(1);
    if (nextPtr >= (IDW+1)'(NUM_REQ)) nextPtr = '0;
  end

  assign depositSum = {1'b0, balance_q} + {1'b0, amt_q};

`ifdef ATM_DAILY_LIMIT_EN
  // A rollover landing in EXEC counts as already applied to this withdrawal.
  assign accEff = day_rollover ? '0 : acc_q;
  assign accSum = {1'b0, accEff} + {1'b0, amt_q};
`endif

  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    rrPtr_d   = rrPtr_q;
    id_d      = id_q;
    op_d      = op_q;
    amt_d     = amt_q;
    status_d  = status_q;
    rspBal_d  = rspBal_q;
    req_ready = '0;
    rsp_valid = '0;
`ifdef ATM_DAILY_LIMIT_EN
    acc_d     = day_rollover ? '0 : acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (winFound) begin
          req_ready[winIdx] = 1'b1;
          id_d    = winIdx;
          op_d    = req_op[2*winIdx +: 2];
          amt_d   = req_amount[AMT_W*winIdx +: AMT_W];
          state_d = EXEC;
        end
      end
      EXEC: begin
        status_d = ST_REJECT;
        case (op_q)
          OP_INQUIRY: status_d = ST_OK;
          OP_WITHDRAW: begin
            if (amt_q > balance_q) begin
              status_d = ST_NOFUNDS;
`ifdef ATM_DAILY_LIMIT_EN
            end else if (accSum > (AMT_W+1)'(DAILY_LIMIT)) begin
              status_d = ST_LIMIT;
`endif
            end else begin
              status_d  = ST_OK;
              balance_d = balance_q - amt_q;
`ifdef ATM_DAILY_LIMIT_EN
              acc_d     = accSum[AMT_W-1:0];
`endif
            end
          end
          OP_DEPOSIT: begin
            if (!depositSum[AMT_W]) begin
              status_d  = ST_OK;
              balance_d = depositSum[AMT_W-1:0];
            end
          end
          default: status_d = ST_REJECT;
        endcase
        rspBal_d = balance_d;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rrPtr_d         = nextPtr[IDW-1:0];
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      balance_q <= AMT_W'(INIT_BALANCE);
      rrPtr_q   <= '0;
      id_q      <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      status_q  <= '0;
      rspBal_q  <= '0;
`ifdef ATM_DAILY_LIMIT_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      rrPtr_q   <= rrPtr_d;
      id_q      <= id_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
      status_q  <= status_d;
      rspBal_q  <= rspBal_d;
`ifdef ATM_DAILY_LIMIT_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign rsp_status  = status_q;
  assign rsp_balance = rspBal_q;
  assign grant_id    = id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed, scoreboard-based bench for atm_ledger_arbiter (default 4 requesters, 16-bit amounts).
module tb_atm_ledger_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AMT_W   = 16;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [AMT_W*NUM_REQ-1:0] req_amount;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [1:0]               rsp_status;
  logic [AMT_W-1:0]         rsp_balance;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     day_rollover;

  atm_ledger_arbiter #(
    .NUM_REQ(NUM_REQ), .AMT_W(AMT_W), .INIT_BALANCE(1000), .DAILY_LIMIT(500)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_balance(rsp_balance),
    .grant_id(grant_id), .busy(busy), .day_rollover(day_rollover)
  );

  typedef struct {
    int          id;
    logic [1:0]  st;
    logic [15:0] bal;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleCnt    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every response pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && rsp_valid != '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        checkOutput("rsp_status", 32'(rsp_status), 32'(e.st));
        checkOutput("rsp_balance", 32'(rsp_balance), 32'(e.bal));
        checkOutput("rsp_latency", 32'(cycleCnt), 32'(e.cyc + 2));
        checkOutput("rsp_grant_id", 32'(grant_id), 32'(e.id));
        checkOutput("rsp_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset_n      = 1'b0;
    req_valid    = '0;
    day_rollover = 1'b0;
    repeat (2) @(negedge clk);
    expQ.delete();
    reset_n = 1'b1;
  endtask

  // Raises one request, waits for its grant, and returns at the EXEC-cycle negedge.
  task automatic applyStimulus(input int id, input logic [1:0] op, input logic [15:0] amt,
                               input logic [1:0] expSt, input logic [15:0] expBal,
                               input bit expectRsp);
    int waited;
    exp_t e;
    @(negedge clk);
    req_op[2*id +: 2]             = op;
    req_amount[AMT_W*id +: AMT_W] = amt;
    req_valid[id]                 = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[id] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("req_ready", 32'(req_ready), 32'(1) << id);
    if (expectRsp && req_ready[id]) begin
      e.id = id; e.st = expSt; e.bal = expBal; e.cyc = cycleCnt;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_grant_id", 32'(grant_id), 32'(id));
  endtask

  initial begin
    int waited;
    int lastCyc;
    exp_t e;
    reset_n      = 1'b0;
    req_valid    = '0;
    req_op       = '0;
    req_amount   = '0;
    day_rollover = 1'b0;
    doReset();
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("reset_rsp_balance", 32'(rsp_balance), 32'd0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    applyStimulus(0, 2'b01, 16'd0,     2'b00, 16'd1000,  1'b1);
    applyStimulus(1, 2'b10, 16'd300,   2'b00, 16'd700,   1'b1);
    applyStimulus(1, 2'b10, 16'd800,   2'b01, 16'd700,   1'b1);
    applyStimulus(2, 2'b10, 16'd700,   2'b00, 16'd0,     1'b1);
    applyStimulus(3, 2'b10, 16'd0,     2'b00, 16'd0,     1'b1);
    applyStimulus(0, 2'b11, 16'd1000,  2'b00, 16'd1000,  1'b1);
    applyStimulus(1, 2'b11, 16'd65000, 2'b11, 16'd1000,  1'b1);
    applyStimulus(2, 2'b00, 16'd5,     2'b11, 16'd1000,  1'b1);
    applyStimulus(3, 2'b11, 16'd64535, 2'b00, 16'd65535, 1'b1);
    applyStimulus(0, 2'b11, 16'd1,     2'b11, 16'd65535, 1'b1);
    repeat (3) @(negedge clk);

    doReset();
`ifdef ATM_DAILY_LIMIT_EN
    applyStimulus(0, 2'b10, 16'd400, 2'b00, 16'd600, 1'b1);
    applyStimulus(1, 2'b10, 16'd200, 2'b10, 16'd600, 1'b1);
    @(negedge clk);
    @(negedge clk);
    day_rollover = 1'b1;
    @(negedge clk);
    day_rollover = 1'b0;
    applyStimulus(2, 2'b10, 16'd200, 2'b00, 16'd400, 1'b1);
`else
    applyStimulus(0, 2'b10, 16'd400, 2'b00, 16'd600, 1'b1);
    applyStimulus(1, 2'b10, 16'd200, 2'b00, 16'd400, 1'b1);
    @(negedge clk);
    @(negedge clk);
    day_rollover = 1'b1;
    @(negedge clk);
    day_rollover = 1'b0;
    applyStimulus(2, 2'b10, 16'd200, 2'b00, 16'd200, 1'b1);
`endif
    repeat (3) @(negedge clk);

    // All four requesters hold inquiries continuously; grants must rotate every third cycle.
    doReset();
    req_op     = {NUM_REQ{2'b01}};
    req_amount = '0;
    req_valid  = '1;
    lastCyc    = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (req_ready == '0 && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      checkOutput("rr_ready", 32'(req_ready), 32'(1) << (k % NUM_REQ));
      if (k > 0) checkOutput("rr_spacing", 32'(cycleCnt - lastCyc), 32'd3);
      lastCyc = cycleCnt;
      e.id = k % NUM_REQ; e.st = 2'b00; e.bal = 16'd1000; e.cyc = cycleCnt;
      expQ.push_back(e);
      @(posedge clk);
      if (k == 4) begin
        #1;
        req_valid = '0;
      end
      @(negedge clk);
      #1;
    end
    repeat (4) @(negedge clk);

    doReset();
    applyStimulus(0, 2'b10, 16'd100, 2'b00, 16'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1, 2'b01, 16'd0, 2'b00, 16'd1000, 1'b1);

    waited = 0;
    while (expQ.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
